// File: rtl/led_sequencer.sv
// Bus-mapped LED colour sequencer: 8-entry 3-bit colour table, per-step dwell, one-shot or looping playback.
// Optional completion interrupt is compiled in with `define LED_SEQ_IRQ_EN.
module led_sequencer #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned DEPTH    = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [1:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       WE,
    output logic [2:0] RGB_OUT,
`ifdef LED_SEQ_IRQ_EN
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] COUNT_FULL = 4'(DEPTH);

    // Bus handshake: a write is accepted on any rising edge with WE && BUS_WE;
    // a read drives BUS_DATA combinationally while WE && !BUS_WE, otherwise the bus floats.
    state_t        state_q, state_d;
    logic          run_q, run_d;
    logic          loop_q, loop_d;
    logic [7:0]    dwell_q, dwell_d;
    logic [3:0]    count_q, count_d;
    logic [2:0]    step_q, step_d;
    logic [2:0]    rgb_q, rgb_d;
    logic [7:0]    dcnt_q, dcnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic [2:0]    table_q [DEPTH];
    logic [2:0]    table_d [DEPTH];

    logic       wr_en;
    logic       wr_ctrl;
    logic       wr_dwell;
    logic       wr_pat;
    logic       busy;
    logic       full;
    logic [7:0] rd_data;

    assign wr_en    = WE && BUS_WE;
    assign wr_ctrl  = wr_en && (BUS_ADDR == 2'd0);
    assign wr_dwell = wr_en && (BUS_ADDR == 2'd1);
    assign wr_pat   = wr_en && (BUS_ADDR == 2'd2);
    assign busy     = (state_q == S_LOAD) || (state_q == S_DWELL);
    assign full     = (count_q == COUNT_FULL);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        loop_d  = loop_q;
        dwell_d = dwell_q;
        count_d = count_q;
        step_d  = step_q;
        rgb_d   = rgb_q;
        dcnt_d  = dcnt_q;
        presc_d = presc_q;
        done_d  = done_q;
        table_d = table_q;

        if (wr_dwell) begin
            dwell_d = BUS_DATA;
        end

        if (wr_pat && !busy && !full) begin
            table_d[count_q[2:0]] = BUS_DATA[2:0];
            count_d = count_q + 4'd1;
        end

        case (state_q)
            S_LOAD: begin
                rgb_d   = table_q[step_q];
                dcnt_d  = (dwell_q == 8'd0) ? 8'd1 : dwell_q;
                presc_d = '0;
                state_d = S_DWELL;
            end
            S_DWELL: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    dcnt_d  = dcnt_q - 8'd1;
                    // dcnt_q == 1 is the tick that takes the dwell counter to zero
                    if (dcnt_q == 8'd1) begin
                        if ({1'b0, step_q} < (count_q - 4'd1)) begin
                            step_d  = step_q + 3'd1;
                            state_d = S_LOAD;
                        end else if (loop_q) begin
                            step_d  = 3'd0;
                            state_d = S_LOAD;
                        end else begin
                            run_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: ;
        endcase

        // CTRL writes override the autonomous sequencing decided above.
        if (wr_ctrl) begin
            loop_d = BUS_DATA[1];
            if (BUS_DATA[2] && !busy) begin
                count_d = 4'd0;
                done_d  = 1'b0;
            end
            if (!BUS_DATA[0]) begin
                run_d   = 1'b0;
                rgb_d   = 3'd0;
                step_d  = 3'd0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end else if (!busy && (count_d != 4'd0)) begin
                run_d   = 1'b1;
                step_d  = 3'd0;
                done_d  = 1'b0;
                state_d = S_LOAD;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            loop_q  <= 1'b0;
            dwell_q <= 8'd0;
            count_q <= 4'd0;
            step_q  <= 3'd0;
            rgb_q   <= 3'd0;
            dcnt_q  <= 8'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            loop_q  <= loop_d;
            dwell_q <= dwell_d;
            count_q <= count_d;
            step_q  <= step_d;
            rgb_q   <= rgb_d;
            dcnt_q  <= dcnt_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Table contents are deliberately left without reset.
    always_ff @(posedge CLK) begin
        table_q <= table_d;
    end

`ifdef LED_SEQ_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (BUS_INTERRUPT_ACK) begin
            irq_d = 1'b0;
        end
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign BUS_INTERRUPT_RAISE = irq_q;
`endif

    always_comb begin
        rd_data = 8'd0;
        case (BUS_ADDR)
            2'd0: rd_data = {6'b0, loop_q, run_q};
            2'd1: rd_data = dwell_q;
            2'd2: rd_data = {4'b0, count_q};
            2'd3: rd_data = {done_q, busy, 1'b0, full, 1'b0, step_q};
            default: rd_data = 8'd0;
        endcase
    end

    assign BUS_DATA  = (WE && !BUS_WE) ? rd_data : 8'hzz;
    assign RGB_OUT   = rgb_q;
    assign state_dbg = state_q;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Bus-mapped controller that sequences the tri-colour LED through a programmable colour pattern. The processor loads up to 8 three-bit colours and a per-step dwell time, then starts the sequence. The block steps RGB_OUT through the table autonomously, either once or in a loop. It sits on the shared 8-bit data bus behind the central address decoder, in place of a directly written LED register.

## Interface
- TICK_DIV, 100000: clock cycles per dwell tick (1 ms at 100 MHz); must be ≥ 2.
- DEPTH, 8: pattern table entries; fixed at 8 (3-bit count/step fields).
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus.
- BUS_ADDR  input  2  register select; low address bits.
- BUS_WE  input  1  processor write enable (1 = write, 0 = read).
- WE  input  1  address-decoder match for this block's 4-byte window.
- RGB_OUT  output  3  LED drive {B,G,R}.
- BUS_INTERRUPT_RAISE  output  1  sequence-done interrupt (only with LED_SEQ_IRQ_EN).
- BUS_INTERRUPT_ACK  input  1  interrupt acknowledge (only with LED_SEQ_IRQ_EN).

## Operation
- Registers, written on WE && BUS_WE at a clock edge:
  - 0 CTRL: bit0 RUN, bit1 LOOP, bit2 CLR (write-1 pulse, reads 0).
  - 1 DWELL: 8-bit ticks per step; 0 is treated as 1.
  - 2 PATTERN: write pushes BUS_DATA[2:0] at table[count] and increments count.
  - 3 STATUS: read-only.
- Reads drive BUS_DATA combinationally when WE && !BUS_WE; otherwise BUS_DATA is 8'hZZ.
- Read values by address:
  - 0: {5'b0, 1'b0, LOOP, RUN}.
  - 1: DWELL.
  - 2: {4'b0, count[3:0]}.
  - 3: {DONE, BUSY, 1'b0, FULL, 1'b0, step[2:0]}.
- FULL = (count == 8). PATTERN writes when FULL are ignored.
- PATTERN and CLR writes are ignored while BUSY (state LOAD or DWELL). CLR sets count to 0 and clears DONE.
- FSM states:
  - IDLE: RGB_OUT = 0. A write of RUN=1 with count > 0 goes to LOAD with step = 0. RUN=1 with count = 0 is ignored and the RUN bit stays 0.
  - LOAD (1 cycle): RGB_OUT <= table[step]; dwell counter <= max(DWELL,1); prescaler <= 0; go to DWELL.
  - DWELL: prescaler counts 0..TICK_DIV-1 and its wrap is a tick. Each tick decrements the dwell counter. On the tick where the counter reaches 0:
    - if step < count-1: step++ and go to LOAD;
    - else if LOOP: step = 0 and go to LOAD;
    - else go to DONE.
  - DONE: RGB_OUT holds the last colour; RUN cleared; DONE = 1. Writing RUN=1 goes to LOAD with step = 0 and clears DONE.
- CTRL write with RUN=0 in any state goes to IDLE next cycle: RGB_OUT = 0, step = 0, DONE cleared. Table and count are kept.
- Writing LOOP while running takes effect at the end of the current step.
- A DWELL write while running affects the next LOAD only.
- Reset values:
  - RUN = LOOP = 0, DWELL = 0, count = 0, step = 0.
  - State IDLE, RGB_OUT = 3'b000, DONE = 0, BUS_INTERRUPT_RAISE = 0.
  - Table contents are undefined.

## Timing
- Register writes take effect at the same rising edge. A RUN write moves the FSM to LOAD at that edge.
- First colour appears on RGB_OUT one cycle after the RUN write edge (LOAD cycle).
- Each step lasts exactly max(DWELL,1)*TICK_DIV + 1 cycles: the LOAD cycle plus DWELL time.
- DONE/BUSY status updates in the same cycle as the state change.
- Reset assertion mid-sequence returns all outputs to reset values immediately, independent of CLK.

## Configuration
- LED_SEQ_IRQ_EN defined:
  - BUS_INTERRUPT_RAISE is set on entry to DONE.
  - It is held until a cycle with BUS_INTERRUPT_ACK = 1, then cleared the next edge.
  - If a new DONE entry coincides with ACK, RAISE stays set.
  - Looping sequences never raise.
- LED_SEQ_IRQ_EN undefined:
  - Both interrupt ports are absent.
  - Completion is visible only through STATUS.DONE.

## Test plan
- Reset then read all four addresses -> 00, 00, 00, 00; RGB_OUT = 000; BUS_DATA = Z when WE = 0.
- TICK_DIV=4, DWELL=2, push 1, 2, 4, RUN=1, LOOP=0:
  - RGB_OUT = 001/010/100, each for 9 cycles.
  - Then DONE: STATUS = 8'h82, RGB_OUT holds 100, CTRL reads 00.
- Push 9 colours -> count reads 8, STATUS.FULL = 1, 9th value absent from the sequence.
- LOOP=1, two entries, DWELL=0 -> colours alternate every 5 cycles indefinitely. A CTRL write of 00 -> RGB_OUT = 000 the next cycle, state IDLE.
- RUN=1 with count = 0 -> stays IDLE, CTRL reads 00. PATTERN write during DWELL -> count unchanged.
- With LED_SEQ_IRQ_EN, one-shot sequence:
  - RAISE = 1 on DONE entry and held through 10 idle cycles.
  - ACK pulse clears it.
  - RESET low mid-DWELL -> RGB_OUT = 000, RAISE = 0 asynchronously.
